// File: rtl/proc_ctrl_pkg.sv
// Shared constants for the processor control FSM: opcodes, state encodings, ALU select bits.
// Optional divide/modulo support is enabled with the PROC_CTRL_DIVMOD_EN macro.
package proc_ctrl_pkg;

   localparam logic [3:0] OP_LOAD = 4'd1;
   localparam logic [3:0] OP_MOVE = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_DIV  = 4'd8;
   localparam logic [3:0] OP_MOD  = 4'd9;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_T1   = 3'd1;
   localparam state_t ST_T2   = 3'd2;
   localparam state_t ST_WAIT = 3'd3;
   localparam state_t ST_T3   = 3'd4;

   localparam int MATH_W   = 7;
   localparam int MATH_XOR = 6;
   localparam int MATH_ADD = 5;
   localparam int MATH_SUB = 4;
   localparam int MATH_AND = 3;
   localparam int MATH_OR  = 2;
   localparam int MATH_DIV = 1;
   localparam int MATH_MOD = 0;

   function automatic logic is_divmod(input logic [3:0] f);
`ifdef PROC_CTRL_DIVMOD_EN
      return (f == OP_DIV) || (f == OP_MOD);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic is_alu_op(input logic [3:0] f);
      logic r;
      case (f)
         OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND: r = 1'b1;
         default:                               r = is_divmod(f);
      endcase
      return r;
   endfunction

   // Disabled divide/modulo never selects its math_en bit.
   function automatic logic [MATH_W-1:0] math_sel(input logic [3:0] f);
      logic [MATH_W-1:0] m;
      m = 7'b000_0000;
      case (f)
         OP_XOR:  m[MATH_XOR] = 1'b1;
         OP_ADD:  m[MATH_ADD] = 1'b1;
         OP_SUB:  m[MATH_SUB] = 1'b1;
         OP_AND:  m[MATH_AND] = 1'b1;
         OP_OR:   m[MATH_OR]  = 1'b1;
         OP_DIV:  m[MATH_DIV] = is_divmod(f);
         OP_MOD:  m[MATH_MOD] = is_divmod(f);
         default: m = 7'b000_0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/proc_ctrl_fsm_onehot_dec.sv
// Combinational binary-index to one-hot decoder.
module onehot_dec #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   // Single set bit at the indexed position.
   always_comb begin
      onehot = N'(1) << idx;
   end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle datapath control FSM (IDLE/T1/T2/WAIT/T3); outputs decode from state and
// the latched instruction. PROC_CTRL_DIVMOD_EN adds div/mod opcodes with the WAIT state.
module proc_ctrl_fsm
   import proc_ctrl_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                run,
   input  logic [3:0]          func,
   input  logic [IDX_W-1:0]    rx,
   input  logic [IDX_W-1:0]    ry,
   input  logic                alu_ready,
   output logic                busy,
   output logic                done,
   output logic                illegal,
   output logic                data_out,
   output logic [NUM_REGS-1:0] r_in,
   output logic [NUM_REGS-1:0] r_out,
   output logic                add_sub,
   output logic                a_in,
   output logic                g_in,
   output logic                g_out,
   output logic [MATH_W-1:0]   math_en
);

   state_t             state_r;
   state_t             state_nx_s;
   logic [3:0]         func_r;
   logic [IDX_W-1:0]   rx_r;
   logic [IDX_W-1:0]   ry_r;
   logic [NUM_REGS-1:0] rx_oh_s;
   logic [NUM_REGS-1:0] ry_oh_s;

`ifndef PROC_CTRL_DIVMOD_EN
   logic unused_alu_ready;
   assign unused_alu_ready = alu_ready;
`endif

   onehot_dec #(.N(NUM_REGS), .IDX_W(IDX_W)) u_rx_dec (.idx(rx_r), .onehot(rx_oh_s));
   onehot_dec #(.N(NUM_REGS), .IDX_W(IDX_W)) u_ry_dec (.idx(ry_r), .onehot(ry_oh_s));

   // State register and instruction register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
         func_r  <= 4'd0;
         rx_r    <= '0;
         ry_r    <= '0;
      end else begin
         state_r <= state_nx_s;
         if ((state_r == ST_IDLE) && run) begin
            func_r <= func;
            rx_r   <= rx;
            ry_r   <= ry;
         end else begin
            func_r <= func_r;
            rx_r   <= rx_r;
            ry_r   <= ry_r;
         end
      end
   end

   // Next-state selection.
   always_comb begin
      state_nx_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (run) state_nx_s = ST_T1;
            else     state_nx_s = ST_IDLE;
         end
         ST_T1: begin
            if (is_alu_op(func_r)) state_nx_s = ST_T2;
            else                   state_nx_s = ST_IDLE;
         end
`ifdef PROC_CTRL_DIVMOD_EN
         ST_T2: begin
            if (is_divmod(func_r) && !alu_ready) state_nx_s = ST_WAIT;
            else                                  state_nx_s = ST_T3;
         end
         ST_WAIT: begin
            if (alu_ready) state_nx_s = ST_T3;
            else           state_nx_s = ST_WAIT;
         end
`else
         ST_T2:   state_nx_s = ST_T3;
`endif
         ST_T3:   state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Control outputs; everything not named for a state stays low.
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      illegal  = 1'b0;
      data_out = 1'b0;
      r_in     = '0;
      r_out    = '0;
      add_sub  = 1'b0;
      a_in     = 1'b0;
      g_in     = 1'b0;
      g_out    = 1'b0;
      math_en  = 7'b000_0000;
      case (state_r)
         ST_IDLE: busy = 1'b0;
         ST_T1: begin
            busy = 1'b1;
            if (func_r == OP_LOAD) begin
               data_out = 1'b1;
               r_in     = rx_oh_s;
               done     = 1'b1;
            end else if (func_r == OP_MOVE) begin
               r_out = ry_oh_s;
               r_in  = rx_oh_s;
               done  = 1'b1;
            end else if (is_alu_op(func_r)) begin
               r_out = rx_oh_s;
               a_in  = 1'b1;
            end else begin
               illegal = 1'b1;
               done    = 1'b1;
            end
         end
         ST_T2: begin
            busy    = 1'b1;
            r_out   = ry_oh_s;
            math_en = math_sel(func_r);
            add_sub = (func_r == OP_SUB);
`ifdef PROC_CTRL_DIVMOD_EN
            if (is_divmod(func_r)) g_in = alu_ready;
            else                   g_in = 1'b1;
`else
            g_in    = 1'b1;
`endif
         end
`ifdef PROC_CTRL_DIVMOD_EN
         ST_WAIT: begin
            busy    = 1'b1;
            r_out   = ry_oh_s;
            math_en = math_sel(func_r);
            g_in    = alu_ready;
         end
`endif
         ST_T3: begin
            busy  = 1'b1;
            g_out = 1'b1;
            r_in  = rx_oh_s;
            done  = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: expected per-cycle output vectors are queued as
// stimulus is driven and compared on the following falling edge.
module tb_proc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       resetn;
   logic       run;
   logic [3:0] func;
   logic [2:0] rx;
   logic [2:0] ry;
   logic       alu_ready;
   logic       busy, done, illegal, data_out, add_sub, a_in, g_in, g_out;
   logic [7:0] r_in, r_out;
   logic [6:0] math_en;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   proc_ctrl_fsm #(.NUM_REGS(8)) dut (
      .clk(clk), .resetn(resetn), .run(run), .func(func), .rx(rx), .ry(ry),
      .alu_ready(alu_ready), .busy(busy), .done(done), .illegal(illegal),
      .data_out(data_out), .r_in(r_in), .r_out(r_out), .add_sub(add_sub),
      .a_in(a_in), .g_in(g_in), .g_out(g_out), .math_en(math_en)
   );

   wire [31:0] obs = {1'b0, busy, done, illegal, data_out, add_sub, a_in, g_in, g_out,
                      math_en, r_out, r_in};

   function automatic logic [31:0] mk(input logic bsy, input logic dn, input logic ill,
                                      input logic dout, input logic asub, input logic ain,
                                      input logic gin, input logic gout, input logic [6:0] m,
                                      input logic [7:0] ro, input logic [7:0] ri);
      return {1'b0, bsy, dn, ill, dout, asub, ain, gin, gout, m, ro, ri};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Pop one expectation per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check_eq(mon_e.tag, obs, mon_e.v);
      end
   end

   task automatic step(input logic rst, input logic r, input logic [3:0] f, input logic [2:0] x,
                       input logic [2:0] y, input logic ar, input logic [31:0] e, input string tag);
      exp_t it;
      @(posedge clk);
      #1;
      resetn    = rst;
      run       = r;
      func      = f;
      rx        = x;
      ry        = y;
      alu_ready = ar;
      it.tag    = tag;
      it.v      = e;
      exp_q.push_back(it);
   endtask

   task automatic do_instr(input logic [3:0] f, input logic [2:0] x, input logic [2:0] y,
                           input int waits, input logic poke);
      logic [7:0] ox, oy, m;
      logic       dm, ar, g;
      ox = 8'd1 << x;
      oy = 8'd1 << y;
      m  = 8'd0;
      dm = 1'b0;
      step(1'b1, 1'b1, f, x, y, 1'b0, 32'd0, "run_idle");
      case (f)
         4'd1: step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0,
                    mk(1, 1, 0, 1, 0, 0, 0, 0, 7'd0, 8'd0, ox), "load_t1");
         4'd2: step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0,
                    mk(1, 1, 0, 0, 0, 0, 0, 0, 7'd0, oy, ox), "move_t1");
         4'd3, 4'd4, 4'd5, 4'd6, 4'd7
`ifdef PROC_CTRL_DIVMOD_EN
         , 4'd8, 4'd9
`endif
         : begin
            case (f)
               4'd3:    m = 8'b0010_0000;
               4'd4:    m = 8'b0001_0000;
               4'd5:    m = 8'b0100_0000;
               4'd6:    m = 8'b0000_0100;
               4'd7:    m = 8'b0000_1000;
               4'd8:    begin m = 8'b0000_0010; dm = 1'b1; end
               default: begin m = 8'b0000_0001; dm = 1'b1; end
            endcase
            step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0,
                 mk(1, 0, 0, 0, 0, 1, 0, 0, 7'd0, ox, 8'd0), "alu_t1");
            ar = (waits == 0);
            g  = dm ? ar : 1'b1;
            step(1'b1, poke, 4'd1, 3'd7, 3'd7, ar,
                 mk(1, 0, 0, 0, (f == 4'd4), 0, g, 0, m[6:0], oy, 8'd0), "alu_t2");
            for (int k = 1; k <= waits; k++) begin
               ar = (k == waits);
               step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, ar,
                    mk(1, 0, 0, 0, 0, 0, ar, 0, m[6:0], oy, 8'd0), "alu_wait");
            end
            step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0,
                 mk(1, 1, 0, 0, 0, 0, 0, 1, 7'd0, 8'd0, ox), "alu_t3");
         end
         default: step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0,
                       mk(1, 1, 1, 0, 0, 0, 0, 0, 7'd0, 8'd0, 8'd0), "illegal_t1");
      endcase
      step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 32'd0, "idle_after");
   endtask

   initial begin
      resetn = 1'b0; run = 1'b0; func = 4'd0; rx = 3'd0; ry = 3'd0; alu_ready = 1'b0;
      step(1'b0, 1'b1, 4'd1, 3'd2, 3'd0, 1'b0, 32'd0, "in_reset");
      step(1'b0, 1'b1, 4'd3, 3'd2, 3'd0, 1'b0, 32'd0, "in_reset");

      do_instr(4'd1, 3'd5, 3'd0, 0, 1'b0);
      check_eq("load_spec_vec", mk(1, 1, 0, 1, 0, 0, 0, 0, 7'd0, 8'd0, 8'b0010_0000),
               {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0, 7'd0, 8'd0, 8'h20});
      do_instr(4'd2, 3'd3, 3'd6, 0, 1'b0);
      do_instr(4'd2, 3'd4, 3'd4, 0, 1'b0);
      do_instr(4'd3, 3'd2, 3'd6, 0, 1'b1);
      do_instr(4'd4, 3'd7, 3'd1, 0, 1'b1);
      do_instr(4'd5, 3'd0, 3'd7, 0, 1'b0);
      do_instr(4'd6, 3'd1, 3'd2, 0, 1'b0);
      do_instr(4'd7, 3'd6, 3'd5, 0, 1'b0);
      do_instr(4'd8, 3'd1, 3'd3, 3, 1'b0);
      do_instr(4'd8, 3'd2, 3'd2, 0, 1'b0);
      do_instr(4'd9, 3'd5, 3'd6, 1, 1'b1);
      do_instr(4'hF, 3'd3, 3'd3, 0, 1'b0);
      do_instr(4'd0, 3'd1, 3'd2, 0, 1'b0);
      do_instr(4'd10, 3'd4, 3'd0, 0, 1'b0);

      // Reset asserted asynchronously during T2 of a sub, then an immediate load after release.
      step(1'b1, 1'b1, 4'd4, 3'd2, 3'd5, 1'b0, 32'd0, "rst_run");
      step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0,
           mk(1, 0, 0, 0, 0, 1, 0, 0, 7'd0, 8'h04, 8'd0), "rst_sub_t1");
      step(1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 32'd0, "rst_in_t2");
      step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 32'd0, "rst_release");
      step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 32'd0, "rst_no_wb");
      do_instr(4'd1, 3'd3, 3'd0, 0, 1'b0);

      step(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 32'd0, "final_idle");
      @(negedge clk);
      #1;
      check_eq("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/proc_ctrl_fsm.md
PROC_CTRL_FSM -- requirements
Module: proc_ctrl_fsm

Interface
REQ-001 Parameter NUM_REGS, default 8, number of general registers; SHALL be a power of two, 2..16.
REQ-002 Parameter IDX_W, default $clog2(NUM_REGS), width of register index fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  start request; qualifies func/rx/ry in IDLE.
REQ-006 func  input  4  opcode.
REQ-007 rx  input  IDX_W  destination / first-operand register index.
REQ-008 ry  input  IDX_W  second-operand / move-source register index.
REQ-009 alu_ready  input  1  divider result valid (used only with DIVMOD_EN).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at instruction completion.
REQ-012 illegal  output  1  one-cycle pulse, coincident with done, for rejected instructions.
REQ-013 data_out  output  1  external-data bus select.
REQ-014 r_in, r_out  output  NUM_REGS each  one-hot register write / bus-drive enables.
REQ-015 add_sub, a_in, g_in, g_out  output  1 each  adder mode (1=sub), A latch, G latch, G bus drive.
REQ-016 math_en  output  7  one-hot ALU select [6]xor [5]add [4]sub [3]and [2]or [1]div [0]mod.

Function
REQ-017 States SHALL be IDLE, T1, T2, WAIT, T3; outputs SHALL decode from state plus instruction register only (no combinational path from func/rx/ry).
REQ-018 In IDLE, run=1 SHALL latch func, rx, ry into the instruction register and move to T1 next cycle; run while busy SHALL be ignored.
REQ-019 Opcodes: 1 load, 2 move, 3 add, 4 sub, 5 xor, 6 or, 7 and, 8 div, 9 mod; all others illegal.
REQ-020 T1 load: data_out=1, r_in=onehot(rx), done=1, -> IDLE (latency 2 cycles from run).
REQ-021 T1 move: r_out=onehot(ry), r_in=onehot(rx), done=1, -> IDLE; rx==ry SHALL still complete normally.
REQ-022 T1 ALU op: r_out=onehot(rx), a_in=1, -> T2.
REQ-023 T2: r_out=onehot(ry), math_en per opcode, add_sub=1 only for sub; g_in=1 and -> T3, except div/mod with alu_ready=0 -> WAIT with g_in=0.
REQ-024 WAIT: r_out=onehot(ry), math_en held; g_in=alu_ready; -> T3 when alu_ready=1, else remain; no timeout.
REQ-025 T3: g_out=1, r_in=onehot(rx), done=1, -> IDLE (ALU latency 4 cycles from run, plus WAIT cycles).
REQ-026 Illegal opcode in T1: illegal=1, done=1, every enable 0, -> IDLE.
REQ-027 Outputs not named for a state SHALL be 0; r_in and r_out SHALL never have more than one bit set.

Reset
REQ-028 resetn low SHALL force IDLE and clear the instruction register immediately, all outputs 0, including mid-instruction and in WAIT; no partial write-back after release.
REQ-029 First run SHALL be accepted on the first rising edge with resetn high.

Configuration
REQ-030 Macro PROC_CTRL_DIVMOD_EN: defined -> opcodes 8/9 execute per REQ-023/024; undefined -> 8/9 are illegal per REQ-026, WAIT state and alu_ready logic absent, math_en[1:0] tied 0.

Structure
REQ-031 Package proc_ctrl_pkg SHALL hold opcode constants, state enum, math_en bit-index constants.
REQ-032 Sub-module onehot_dec (parameter N, index in, N-bit one-hot out, combinational) SHALL be instantiated for rx and ry.

Verification
REQ-033 NUM_REGS=8, run with func=1 rx=5 -> T1: data_out=1, r_in=8'b0010_0000, done=1; busy low next cycle.
REQ-034 func=3 rx=2 ry=6 -> T1 r_out=0x04 a_in=1; T2 r_out=0x40 g_in=1 math_en=7'b0100000; T3 g_out=1 r_in=0x04 done=1.
REQ-035 func=8 rx=1 ry=3, alu_ready low 3 cycles -> 3 WAIT cycles, g_in=0 until alu_ready=1, done 7 cycles after run (4 without WAIT); without macro -> illegal=1 at T1.
REQ-036 func=4'hF -> illegal=1, done=1 at T1, all enables 0; run pulsed during a busy add -> ignored.
REQ-037 resetn low in T2 of sub -> all outputs 0 asynchronously; after release, no r_in pulse and busy=0.
